// File: rtl/i2s_adc_rx.sv
`timescale 1ns/1ps
// I2S ADC receiver: clock master toward the ADC, deserializes stereo samples into a FIFO read over iomem.
// Latency: pin -> shift register 2 sync cycles + sample point; frame reaches FIFO 1 cycle after last right bit.
// Backpressure: none toward the ADC; a frame arriving at a full FIFO (no same-cycle pop) is dropped and sets sticky overflow.
//
// Ports: clk/resetn (sync, active-low); ad_mclk/ad_sclk/ad_lrck/ad_sdout to the ADC;
//        iomem_* single-cycle-ack bus responder at page ADDR_HI; irq while FIFO is at least half full.
module i2s_adc_rx #(
  parameter logic [7:0] ADDR_HI     = 8'h06,
  parameter int         SAMPLE_BITS = 24,
  parameter int         FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ad_mclk,
  output logic        ad_lrck,
  output logic        ad_sclk,
  input  logic        ad_sdout,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  localparam int         PTR_W     = $clog2(FIFO_DEPTH);
  localparam int         LVL_W     = PTR_W + 1;
  localparam int         FRAME_W   = 2 * SAMPLE_BITS;
  localparam logic [4:0] LAST_SLOT = 5'(SAMPLE_BITS);

  // control / status
  logic enable;
  logic overflow;

  // clock divider and capture path
  logic [8:0]             div_cnt;
  logic                   sdout_meta;
  logic                   sdout_sync;
  logic [SAMPLE_BITS-1:0] shift_reg;
  logic [SAMPLE_BITS-1:0] left_hold;

  // frame FIFO
  logic [FRAME_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;

  // ---------------------------------------------------------------------------
  // Bus decode. An access is acknowledged on the edge where iomem_ready rises;
  // every side effect is tied to that single edge.
  // ---------------------------------------------------------------------------
  logic       bus_hit;
  logic       bus_rd;
  logic       bus_wr;
  logic [1:0] reg_sel;
  logic       ctrl_wr;
  logic       enable_nxt;
  logic       run;

  assign bus_hit    = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_HI);
  assign bus_rd     = bus_hit && (iomem_wstrb == 4'b0000);
  assign bus_wr     = bus_hit && (iomem_wstrb != 4'b0000);
  assign reg_sel    = iomem_addr[3:2];
  assign ctrl_wr    = bus_wr && (reg_sel == 2'd0) && iomem_wstrb[0];
  assign enable_nxt = ctrl_wr ? iomem_wdata[0] : enable;

  // Looking at enable_nxt makes a disable zero the divider on the write edge
  // itself, so the ADC clocks are low from the very next cycle; an enable
  // write leaves div_cnt at 0 for one more cycle so the frame starts at slot 0.
  assign run = enable && enable_nxt;

  // ---------------------------------------------------------------------------
  // Slot timing. Bit k of a sample sits in slot k+1 (one-slot I2S delay) and
  // is sampled at div_cnt[2:0] == 6, well after the synchronizer has settled on
  // the value the ADC launched at the SCLK falling edge.
  // ---------------------------------------------------------------------------
  logic [4:0] slot;
  logic       sample_pt;
  logic       chan_done;
  logic       left_done;
  logic       frame_done;

  assign slot       = div_cnt[7:3];
  assign sample_pt  = run && (div_cnt[2:0] == 3'd6) && (slot != 5'd0) && (slot <= LAST_SLOT);
  assign chan_done  = run && (div_cnt[2:0] == 3'd7) && (slot == LAST_SLOT);
  assign left_done  = chan_done && !div_cnt[8];
  assign frame_done = chan_done && div_cnt[8];

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic               fifo_empty;
  logic               fifo_full;
  logic               do_pop;
  logic               do_push;
  logic               drop;
  logic [FRAME_W-1:0] head;
  logic [SAMPLE_BITS-1:0] head_left;
  logic [SAMPLE_BITS-1:0] head_right;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
  assign do_pop     = bus_rd && (reg_sel == 2'd2) && !fifo_empty;
  // At full a same-cycle pop frees the slot being written, so the push lands.
  assign do_push    = frame_done && (!fifo_full || do_pop);
  assign drop       = frame_done && fifo_full && !do_pop;

  assign head       = fifo_mem[rd_ptr];
  assign head_left  = head[FRAME_W-1:SAMPLE_BITS];
  assign head_right = head[SAMPLE_BITS-1:0];

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      2'd0: begin
        rd_val[0]    = enable;
        rd_val[1]    = overflow;
        rd_val[13:8] = 6'(level);
        rd_val[16]   = fifo_empty;
      end
      2'd1: if (!fifo_empty) rd_val = {{(32-SAMPLE_BITS){head_left[SAMPLE_BITS-1]}}, head_left};
      2'd2: if (!fifo_empty) rd_val = {{(32-SAMPLE_BITS){head_right[SAMPLE_BITS-1]}}, head_right};
      default: rd_val = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      enable      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      iomem_ready <= bus_hit;
      if (bus_rd) iomem_rdata <= rd_val;
      enable <= enable_nxt;
      // A drop in the same cycle as a clear wins: that frame really was lost.
      if (drop) overflow <= 1'b1;
      else if (ctrl_wr && iomem_wdata[1]) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_cnt    <= '0;
      sdout_meta <= 1'b0;
      sdout_sync <= 1'b0;
      shift_reg  <= '0;
      left_hold  <= '0;
    end else begin
      sdout_meta <= ad_sdout;
      sdout_sync <= sdout_meta;
      if (run) begin
        div_cnt <= div_cnt + 9'd1;
        if (sample_pt) shift_reg <= {shift_reg[SAMPLE_BITS-2:0], sdout_sync};
        if (left_done) left_hold <= shift_reg;
      end else begin
        // Stopping discards any half-received frame.
        div_cnt   <= '0;
        shift_reg <= '0;
        left_hold <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      irq    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      irq <= (level >= LVL_W'(FIFO_DEPTH / 2));
    end
  end

  // Storage needs no reset: entries are only visible through level.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= {left_hold, shift_reg};
  end

  // Clock outputs come straight from divider register bits.
  assign ad_mclk = div_cnt[0];
  assign ad_sclk = div_cnt[2];
  assign ad_lrck = div_cnt[8];

  // Address and data bits outside the decoded fields.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:2]};

endmodule

// File: tb/tb_i2s_adc_rx.sv
`timescale 1ns/1ps
// Bench for i2s_adc_rx: bus-functional ADC model plus iomem master, reads scored through a queue.
// Latency: reads are checked on the cycle iomem_ready is seen.
// Backpressure: none; every bus wait and every DUT-event wait is bounded.
module tb_i2s_adc_rx;

  logic        clk;
  logic        resetn;
  logic        ad_mclk;
  logic        ad_lrck;
  logic        ad_sclk;
  logic        ad_sdout;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        irq;

  i2s_adc_rx #(.ADDR_HI(8'h06), .SAMPLE_BITS(24), .FIFO_DEPTH(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ad_mclk     (ad_mclk),
    .ad_lrck     (ad_lrck),
    .ad_sclk     (ad_sclk),
    .ad_sdout    (ad_sdout),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: expected read data queued at issue, compared on acknowledge.
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  string       name_q[$];

  always @(negedge clk) begin
    if (iomem_valid && iomem_ready && iomem_wstrb == 4'b0000) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: read data 0x%08h with nothing expected", iomem_rdata);
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, iomem_rdata, e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ADC model: tracks slots from the DUT clocks, launches one bit per SCLK
  // falling edge, MSB in slot 1. Slot 0 and unused slots carry 1s so any
  // capture outside slots 1..24 corrupts the sample. Frame n carries
  // lbase+n / rbase+n; n restarts whenever the clocks have stopped.
  // ---------------------------------------------------------------------------
  logic [23:0] lbase = 24'h0;
  logic [23:0] rbase = 24'h0;
  int          slot  = 0;
  int          fidx  = 0;
  logic        prev_mclk = 1'b0;
  logic        prev_sclk = 1'b0;
  logic        prev_lrck = 1'b0;

  always @(posedge clk) begin
    logic [23:0] smp;
    #1;
    if (!ad_mclk && !prev_mclk) begin
      slot = 0;
      fidx = 0;
    end else if (ad_lrck != prev_lrck) begin
      slot = 0;
      if (!ad_lrck) fidx++;
    end else if (prev_sclk && !ad_sclk) begin
      slot++;
    end
    smp = ad_lrck ? (rbase + 24'(fidx)) : (lbase + 24'(fidx));
    if (slot >= 1 && slot <= 24) ad_sdout = smp[24 - slot];
    else                         ad_sdout = 1'b1;
    prev_mclk = ad_mclk;
    prev_sclk = ad_sclk;
    prev_lrck = ad_lrck;
  end

  // ---------------------------------------------------------------------------
  // Bus master. Called at posedge+1; returns at posedge+1.
  // ---------------------------------------------------------------------------
  localparam logic [31:0] PAGE = 32'h0600_0000;

  task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input string name, input logic [31:0] exp);
    int          n;
    logic [31:0] junk_e;
    string       junk_n;
    if (wstrb == 4'b0000) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    iomem_addr  = addr;
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    iomem_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!iomem_ready && n < 20);
    if (!iomem_ready) begin
      checks++;
      failures++;
      $display("FAIL %s: no iomem_ready within 20 cycles", name);
      if (wstrb == 4'b0000) begin
        junk_e = exp_q.pop_back();
        junk_n = name_q.pop_back();
      end
    end
    @(posedge clk);
    #1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
  endtask

  task automatic rd(input logic [1:0] off, input string name, input logic [31:0] exp);
    bus_xfer(PAGE | {28'h0, off, 2'b00}, 4'b0000, 32'h0, name, exp);
  endtask

  task automatic wr(input logic [1:0] off, input logic [3:0] strb, input logic [31:0] data);
    bus_xfer(PAGE | {28'h0, off, 2'b00}, strb, data, "write", 32'h0);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int   bad;
    int   n;
    int   mr[2], sr[2], lr[2];
    int   mn, sn, ln, lrck_edges, lrck_bad;
    logic pm, ps, pl;

    resetn      = 1'b0;
    ad_sdout    = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    step(5);
    resetn = 1'b1;
    step(1);

    // ---- reset / idle --------------------------------------------------------
    check("reset_outputs", {26'h0, ad_mclk, ad_sclk, ad_lrck, irq, iomem_ready, |iomem_rdata}, 32'h0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (ad_mclk || ad_sclk || ad_lrck || irq) bad++;
    end
    check("idle_clocks_low", bad, 0);
    rd(2'd0, "reset_ctrl", 32'h0001_0000);
    rd(2'd1, "empty_left", 32'h0);
    rd(2'd2, "empty_right", 32'h0);
    rd(2'd3, "reg3_zero", 32'h0);
    wr(2'd1, 4'b1111, 32'hFFFF_FFFF);
    wr(2'd0, 4'b0010, 32'h0000_0003);
    rd(2'd0, "ignored_writes_ctrl", 32'h0001_0000);

    // Wrong page must never be acknowledged.
    iomem_addr  = 32'h0700_0000;
    iomem_wstrb = 4'b0000;
    iomem_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (iomem_ready) bad++;
    end
    iomem_valid = 1'b0;
    check("other_page_no_ack", bad, 0);

    // ---- clocking + first capture --------------------------------------------
    lbase = 24'h123456;
    rbase = 24'hABCDEF;
    wr(2'd0, 4'b0001, 32'h1);
    pm = ad_mclk; ps = ad_sclk; pl = ad_lrck;
    mn = 0; sn = 0; ln = 0; lrck_edges = 0; lrck_bad = 0;
    mr = '{0, 0}; sr = '{0, 0}; lr = '{0, 0};
    for (int c = 0; c < 850; c++) begin
      step(1);
      if (ad_mclk && !pm && mn < 2) begin mr[mn] = c; mn++; end
      if (ad_sclk && !ps && sn < 2) begin sr[sn] = c; sn++; end
      if (ad_lrck && !pl && ln < 2) begin lr[ln] = c; ln++; end
      if (ad_lrck != pl) begin
        lrck_edges++;
        if (!(ps && !ad_sclk)) lrck_bad++;
      end
      pm = ad_mclk; ps = ad_sclk; pl = ad_lrck;
    end
    check("mclk_period", mr[1] - mr[0], 2);
    check("sclk_period", sr[1] - sr[0], 8);
    check("lrck_period", lr[1] - lr[0], 512);
    check("lrck_edge_count", lrck_edges, 3);
    check("lrck_on_sclk_fall", lrck_bad, 0);
    rd(2'd0, "first_frame_level", 32'h0000_0101);
    rd(2'd1, "capture_left", 32'h0012_3456);
    rd(2'd2, "capture_right", 32'hFFAB_CDEF);
    rd(2'd0, "after_pop_ctrl", 32'h0001_0001);
    wr(2'd0, 4'b0001, 32'h0);
    rd(2'd0, "disabled_empty_ctrl", 32'h0001_0000);

    // ---- overflow: 17 frames, no reads -----------------------------------------
    lbase = 24'h100000;
    rbase = 24'hF00000;
    wr(2'd0, 4'b0001, 32'h1);
    step(8800);
    check("irq_full", {31'h0, irq}, 32'h1);
    rd(2'd0, "overflow_ctrl", 32'h0000_1003);
    rd(2'd1, "overflow_head_left", 32'h0010_0000);
    wr(2'd0, 4'b0001, 32'h3);
    rd(2'd0, "overflow_cleared", 32'h0000_1001);

    // ---- RIGHT read acknowledged on the push edge of frame 17 ----------------
    bad = 0;
    n = 0;
    pl = ad_lrck;
    while (!(ad_lrck && !pl) && n < 1000) begin
      pl = ad_lrck;
      step(1);
      n++;
      if (!irq) bad++;
    end
    check("lrck_rise_seen", {31'h0, ad_lrck && !pl}, 32'h1);
    for (int c = 0; c < 199; c++) begin
      step(1);
      if (!irq) bad++;
    end
    rd(2'd2, "push_pop_right", 32'hFFF0_0000);
    if (!irq) bad++;
    rd(2'd0, "push_pop_ctrl", 32'h0000_1001);
    if (!irq) bad++;
    check("irq_held_at_full", bad, 0);

    // ---- drain with FIFO retained across disable -----------------------------
    wr(2'd0, 4'b0001, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      rd(2'd2, "drain_right", 32'hFFF0_0000 + 32'(k));
      check("drain_irq", {31'h0, irq}, (16 - k >= 8) ? 32'h1 : 32'h0);
    end
    for (int k = 10; k <= 15; k++) rd(2'd2, "drain_right", 32'hFFF0_0000 + 32'(k));
    rd(2'd2, "frame17_right", 32'hFFF0_0011);
    rd(2'd0, "drained_ctrl", 32'h0001_0000);

    // ---- mid-frame disable during left slot 10 --------------------------------
    lbase = 24'h2ACE13;
    rbase = 24'h13579B;
    wr(2'd0, 4'b0001, 32'h1);
    n = 0;
    pl = ad_lrck;
    while (!(!ad_lrck && pl) && n < 1200) begin
      pl = ad_lrck;
      step(1);
      n++;
    end
    check("second_frame_start", {31'h0, !ad_lrck && pl}, 32'h1);
    n = 0;
    bad = 0;
    ps = ad_sclk;
    while (bad < 10 && n < 200) begin
      step(1);
      n++;
      if (ps && !ad_sclk) bad++;
      ps = ad_sclk;
    end
    check("slot10_reached", bad, 10);
    wr(2'd0, 4'b0001, 32'h0);
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      if (ad_mclk || ad_sclk || ad_lrck) bad++;
      step(1);
    end
    check("clocks_stop_on_disable", bad, 0);
    rd(2'd0, "disable_keeps_level", 32'h0000_0100);

    lbase = 24'h5B3C71;
    rbase = 24'h7F00FF;
    wr(2'd0, 4'b0001, 32'h1);
    step(520);
    rd(2'd1, "kept_left", 32'h002A_CE13);
    rd(2'd2, "kept_right", 32'h0013_579B);
    rd(2'd1, "reenable_left", 32'h005B_3C71);
    rd(2'd2, "reenable_right", 32'h007F_00FF);
    rd(2'd0, "reenable_ctrl", 32'h0001_0001);
    wr(2'd0, 4'b0001, 32'h0);

    step(2);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
